// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// lfsr_pkg : shared FSM encoding, LFSR defaults and feedback helper
// Rev 1.0  : initial release
// ============================================================================
package lfsr_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam logic [7:0]  DEF_TAPS  = 8'hB8;
  localparam logic [7:0]  DEF_SEED  = 8'h01;
  localparam int unsigned CNT_W     = 16;

  // Callers zero-extend state and taps, so any WIDTH up to 64 is supported.
  function automatic logic lfsr_feedback(input logic [63:0] state,
                                         input logic [63:0] taps);
    return ^(state & taps);
  endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// lfsr_core : Fibonacci LFSR register with load and step enable
// Rev 1.0   : initial release
// ============================================================================
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS         = DEF_TAPS,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = DEF_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state,
  output logic             q
);

  logic fb;

  assign fb = lfsr_feedback(64'(state), 64'(TAPS));
  assign q  = state[WIDTH-1];

  // An all-zero load would lock the register, so the default seed replaces it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DEFAULT_SEED;
    end else if (load) begin
      state <= (load_val == '0) ? DEFAULT_SEED : load_val;
    end else if (en) begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

endmodule : lfsr_core
`default_nettype wire

// File: rtl/lfsr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// lfsr_burst_ctrl : seeds an LFSR, runs WORD_W-bit bursts, hands words out
// Rev 1.0         : initial release
// ============================================================================
module lfsr_burst_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS         = DEF_TAPS,
  parameter int unsigned       WORD_W       = 8,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = DEF_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_valid,
  input  logic [WIDTH-1:0]  seed_data,
  output logic              seed_ready,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  output logic              busy,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  input  logic              word_ready,
  output logic              done,
  output logic              q
);

  localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t             st;
  logic [CNT_W-1:0]   remaining;
  logic [BIT_W-1:0]   bit_cnt;
  logic               bit_last;
  logic               lfsr_en;
  logic               lfsr_load;
  logic [WIDTH-1:0]   lfsr_state;
  logic [WORD_W-1:0]  word_next;

  assign seed_ready = (st == S_IDLE);
  assign busy       = (st != S_IDLE);
  assign bit_last   = (bit_cnt == BIT_W'(WORD_W - 1));

  // Abort freezes the register on the cycle it is seen.
  assign lfsr_en   = (st == S_SHIFT) && !abort;
  assign lfsr_load = (st == S_IDLE) && seed_valid;

  generate
    if (WORD_W == 1) begin : g_word_single
      assign word_next = lfsr_state[WIDTH-1];
    end else begin : g_word_multi
      assign word_next = {word_data[WORD_W-2:0], lfsr_state[WIDTH-1]};
    end
  endgenerate

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (lfsr_en),
    .load     (lfsr_load),
    .load_val (seed_data),
    .state    (lfsr_state),
    .q        (q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= S_IDLE;
      remaining  <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (st != S_IDLE)) begin
        st         <= S_IDLE;
        word_valid <= 1'b0;
      end else begin
        case (st)
          S_IDLE: begin
            if (start) begin
              remaining <= word_count;
              bit_cnt   <= '0;
              if (word_count != '0) begin
                st <= S_SHIFT;
              end else begin
                st   <= S_DONE;
                done <= 1'b1;
              end
            end
          end
          S_SHIFT: begin
            word_data <= word_next;
            if (bit_last) begin
              bit_cnt    <= '0;
              st         <= S_HOLD;
              word_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_HOLD: begin
            if (word_ready) begin
              word_valid <= 1'b0;
              remaining  <= remaining - 1'b1;
              if (remaining == CNT_W'(1)) begin
                st   <= S_DONE;
                done <= 1'b1;
              end else begin
                st <= S_SHIFT;
              end
            end
          end
          S_DONE: begin
            st <= S_IDLE;
          end
          default: begin
            st <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule : lfsr_burst_ctrl
`default_nettype wire

// File: tb/tb_lfsr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// tb_lfsr_burst_ctrl : directed vectors for the LFSR burst controller
// Rev 1.0            : initial release
// ============================================================================
module tb_lfsr_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_valid;
  logic [7:0]  seed_data;
  logic        seed_ready;
  logic        start;
  logic [15:0] word_count;
  logic        abort;
  logic        busy;
  logic        word_valid;
  logic [7:0]  word_data;
  logic        word_ready;
  logic        done;
  logic        q;

  int n_vec = 0;
  int n_err = 0;

  lfsr_burst_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .seed_ready (seed_ready),
    .start      (start),
    .word_count (word_count),
    .abort      (abort),
    .busy       (busy),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .done       (done),
    .q          (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            do_seed;
    logic            seed_with_start;
    logic [7:0]      seed;
    logic [15:0]     count;
    logic [2:0][7:0] exp;
  } burst_t;

  burst_t tbl [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives one start (optionally with a same-cycle seed) and clocks it in.
  task automatic kick(input logic sv, input logic [7:0] sd, input logic [15:0] cnt);
    seed_valid = sv;
    seed_data  = sd;
    start      = 1'b1;
    word_count = cnt;
    step();
    start      = 1'b0;
    seed_valid = 1'b0;
  endtask

  // Counts cycles from the triggering edge until word_valid, bounded.
  task automatic wait_word(output int lat);
    lat = 1;
    while (!word_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run_burst(input burst_t b);
    int lat;
    if (b.do_seed && !b.seed_with_start) begin
      seed_valid = 1'b1;
      seed_data  = b.seed;
      step();
      seed_valid = 1'b0;
    end
    kick(b.do_seed && b.seed_with_start, b.seed, b.count);
    for (int w = 0; w < int'(b.count); w++) begin
      wait_word(lat);
      check("word_latency", 32'(lat), 32'd9);
      check("word_data", 32'(word_data), 32'(b.exp[w]));
      if (lat >= 40) return;
      check("no_early_done", 32'(done), 32'd0);
      step();
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    step();
    check("done_cleared", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;

    tbl[0] = '{do_seed:1'b1, seed_with_start:1'b0, seed:8'h01, count:16'd2,
               exp:{8'h00, 8'h1C, 8'h01}};
    tbl[1] = '{do_seed:1'b1, seed_with_start:1'b0, seed:8'h00, count:16'd1,
               exp:{8'h00, 8'h00, 8'h01}};
    tbl[2] = '{do_seed:1'b0, seed_with_start:1'b0, seed:8'h00, count:16'd1,
               exp:{8'h00, 8'h00, 8'h1C}};
    tbl[3] = '{do_seed:1'b1, seed_with_start:1'b1, seed:8'h8E, count:16'd1,
               exp:{8'h00, 8'h00, 8'h8E}};
    tbl[4] = '{do_seed:1'b0, seed_with_start:1'b0, seed:8'h00, count:16'd3,
               exp:{8'hC9, 8'hC0, 8'h25}};

    reset      = 1'b1;
    seed_valid = 1'b0;
    seed_data  = 8'h00;
    start      = 1'b0;
    word_count = 16'd0;
    abort      = 1'b0;
    word_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    check("rst_seed_ready", 32'(seed_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_data", 32'(word_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(q), 32'd0);

    for (int i = 0; i < 5; i++) run_burst(tbl[i]);

    // Seed offered mid-burst must be ignored.
    kick(1'b1, 8'h01, 16'd1);
    step();
    seed_valid = 1'b1;
    seed_data  = 8'h55;
    check("seed_ready_shift", 32'(seed_ready), 32'd0);
    step();
    seed_valid = 1'b0;
    wait_word(lat);
    check("ign_seed_word", 32'(word_data), 32'h01);
    check("ign_seed_valid", 32'(word_valid), 32'd1);
    step();
    check("ign_seed_done", 32'(done), 32'd1);
    step();

    // Backpressure: word held while word_ready is low.
    word_ready = 1'b0;
    seed_valid = 1'b1;
    seed_data  = 8'h01;
    step();
    seed_valid = 1'b0;
    kick(1'b0, 8'h00, 16'd2);
    wait_word(lat);
    check("hold_latency", 32'(lat), 32'd9);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 32'(word_valid), 32'd1);
      check("hold_data", 32'(word_data), 32'h01);
      check("hold_q", 32'(q), 32'd0);
    end
    word_ready = 1'b1;
    step();
    check("hold_accept_drop", 32'(word_valid), 32'd0);
    wait_word(lat);
    check("hold_second_lat", 32'(lat), 32'd9);
    check("hold_second_word", 32'(word_data), 32'h1C);
    step();
    check("hold_done", 32'(done), 32'd1);
    step();

    // Abort three steps into word 2: register stops at 0xE2.
    seed_valid = 1'b1;
    seed_data  = 8'h01;
    step();
    seed_valid = 1'b0;
    kick(1'b0, 8'h00, 16'd3);
    wait_word(lat);
    check("abort_word1", 32'(word_data), 32'h01);
    step();
    repeat (3) step();
    check("abort_q_before", 32'(q), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(word_valid), 32'd0);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_q_kept", 32'(q), 32'd1);
    step();
    check("abort_no_done2", 32'(done), 32'd0);
    kick(1'b0, 8'h00, 16'd1);
    wait_word(lat);
    check("abort_resume_word", 32'(word_data), 32'hE2);
    step();
    check("abort_resume_done", 32'(done), 32'd1);
    step();

    // Zero-length burst.
    kick(1'b0, 8'h00, 16'd0);
    check("zero_busy", 32'(busy), 32'd1);
    check("zero_done", 32'(done), 32'd1);
    check("zero_valid", 32'(word_valid), 32'd0);
    step();
    check("zero_done_clr", 32'(done), 32'd0);
    check("zero_busy_clr", 32'(busy), 32'd0);

    // Reset mid-burst restores the default seed.
    kick(1'b1, 8'h8E, 16'd2);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_q", 32'(q), 32'd0);
    kick(1'b0, 8'h00, 16'd1);
    wait_word(lat);
    check("midrst_word", 32'(word_data), 32'h01);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_lfsr_burst_ctrl
`default_nettype wire
